// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector: per-channel FSM states
// and the per-channel edge-select encoding.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    EDGE_RISE = 2'd1,
    IDLE_HI   = 2'd2,
    EDGE_FALL = 2'd3
  } edge_state_t;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  // Width of the glitch-filter persistence counter (FILT_LEN up to 255).
  localparam int FILT_CNT_W = 8;

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: persistence filter, level-driven Moore FSM,
// sticky event flag and saturating event counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int FILT_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             level,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};

  logic [FILT_CNT_W-1:0] filt_cnt;
  edge_state_t           state;
  edge_state_t           state_next;
  edge_mode_t            mode_reg;

  // A new raw level must be seen on FILT_LEN consecutive edges to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level    <= 1'b0;
      filt_cnt <= '0;
    end else if (in != level) begin
      if (filt_cnt == FILT_LAST) begin
        level    <= in;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE_LO;
      mode_reg <= EM_OFF;
    end else begin
      state    <= state_next;
      mode_reg <= edge_mode_t'(mode);
    end
  end

  always_comb begin
    state_next = state;
    pulse      = 1'b0;
    case (state)
      IDLE_LO: begin
        if (level) state_next = EDGE_RISE;
      end
      EDGE_RISE: begin
        pulse      = (mode_reg == EM_RISE) || (mode_reg == EM_BOTH);
        state_next = level ? IDLE_HI : EDGE_FALL;
      end
      IDLE_HI: begin
        if (!level) state_next = EDGE_FALL;
      end
      EDGE_FALL: begin
        pulse      = (mode_reg == EM_FALL) || (mode_reg == EM_BOTH);
        state_next = level ? EDGE_RISE : IDLE_LO;
      end
      default: state_next = IDLE_LO;
    endcase
  end

  // A pulse arriving with clr wins: the flag stays set and the count restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky  <= 1'b0;
      evt_cnt <= '0;
    end else begin
      if (pulse)    sticky <= 1'b1;
      else if (clr) sticky <= 1'b0;

      if (clr)
        evt_cnt <= pulse ? CNT_W'(1) : '0;
      else if (pulse && (evt_cnt != CNT_MAX))
        evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// N_CH independent filtered edge detectors with a global "any event" flag.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int FILT_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       pulse,
  output logic [N_CH-1:0]       sticky,
  output logic [N_CH*CNT_W-1:0] evt_cnt,
  output logic                  any_evt
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      edge_chan #(
        .FILT_LEN(FILT_LEN),
        .CNT_W   (CNT_W)
      ) u_chan (
        .clk    (clk),
        .rst    (rst),
        .in     (in[gi]),
        .mode   (mode[2*gi +: 2]),
        .clr    (clr[gi]),
        .level  (level[gi]),
        .pulse  (pulse[gi]),
        .sticky (sticky[gi]),
        .evt_cnt(evt_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign any_evt = |sticky;

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter FILT_LEN, default 3: consecutive cycles a new raw level must persist before it is accepted, range 1..255.
REQ-003 Parameter CNT_W, default 8: width of each per-channel event counter, range 1..16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in  input  N_CH  raw channel levels; synchronous to clk, with synchronisation done outside this block.
REQ-007 mode  input  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 clr  input  N_CH  per-channel clear of sticky flag and event counter.
REQ-009 level  output  N_CH  filtered level per channel.
REQ-010 pulse  output  N_CH  one-cycle edge pulse per channel.
REQ-011 sticky  output  N_CH  latched event flag per channel.
REQ-012 evt_cnt  output  N_CH*CNT_W  saturating event count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-013 any_evt  output  1  OR-reduction of sticky.

Function
REQ-014 Each channel SHALL be fully independent; behaviour for channel i depends only on in[i], mode[i], and clr[i].
REQ-015 Filter: count increments on each edge where in != level, and resets to 0 on any edge where in == level.
REQ-016 When in != level and count == FILT_LEN-1 on an edge, level takes in and count clears; with FILT_LEN=1, level lags in by 1 cycle.
REQ-017 Latency: for the first edge k sampling in != level and no reversal afterwards, level changes at edge k+FILT_LEN-1 and pulse is high from edge k+FILT_LEN to k+FILT_LEN+1.
REQ-018 Per-channel Moore FSM with states IDLE_LO, EDGE_RISE, IDLE_HI, EDGE_FALL, driven by level only.
REQ-019 Transitions: IDLE_LO with level=1 goes to EDGE_RISE; IDLE_HI with level=0 goes to EDGE_FALL.
REQ-020 EDGE_RISE goes to IDLE_HI if level=1, else to EDGE_FALL; EDGE_FALL goes to IDLE_LO if level=0, else to EDGE_RISE; all other cases hold state.
REQ-021 mode SHALL be registered each cycle; pulse is a function of FSM state and registered mode only, so a mode change takes effect 1 cycle later.
REQ-022 pulse[i]=1 in EDGE_RISE when registered mode bit0=1, and in EDGE_FALL when registered mode bit1=1; mode 00 tracks state but never pulses.
REQ-023 sticky[i] SHALL set on any cycle pulse[i]=1; clr[i] clears it; when pulse and clr coincide, set wins.
REQ-024 evt_cnt[i] increments on each pulse[i] and saturates at 2^CNT_W-1, with no wrap.
REQ-025 clr[i] zeroes evt_cnt[i] on the next edge; when pulse and clr coincide, the result is 1.
REQ-026 clr SHALL NOT affect level, filter count, or FSM state.

Reset
REQ-027 rst SHALL asynchronously force level=0, filter counts=0, every FSM to IDLE_LO, registered mode=00, pulse=0, sticky=0, evt_cnt=0, any_evt=0.
REQ-028 If in=1 at reset release, a rising edge SHALL be detected after REQ-017 latency.
REQ-029 Reset asserted mid-filter or mid-pulse SHALL abort the operation with no residual pulse after release.

Structure
REQ-030 Package edge_pkg SHALL hold enum edge_state_t {IDLE_LO, EDGE_RISE, IDLE_HI, EDGE_FALL} and enum edge_mode_t {EM_OFF, EM_RISE, EM_FALL, EM_BOTH}.
REQ-031 Sub-module edge_chan SHALL implement one channel (filter, FSM, sticky, counter); the top SHALL instantiate N_CH copies via generate and OR the sticky flags into any_evt.

Verification
REQ-032 FILT_LEN=3, mode=01: in[0] 0 to 1 at edge 10, held → level[0] rises at edge 12, pulse[0] high for exactly cycle 13, evt_cnt[0]=1.
REQ-033 FILT_LEN=3: in[1] high for 2 cycles then low → level[1], pulse[1], and sticky[1] stay 0.
REQ-034 mode=11, in[2] toggled with period 10 cycles for 3 periods → 6 pulses, evt_cnt[2]=6; with mode=01 the same stimulus gives 3.
REQ-035 CNT_W=2, 5 rising edges → evt_cnt saturates at 3; clr coincident with a pulse → sticky=1 and evt_cnt=1.
REQ-036 rst asserted 1 cycle after level rises, during EDGE_RISE → all outputs 0 immediately; with in held 1, the pulse recurs FILT_LEN+1 cycles after release.
REQ-037 All 4 channels stimulated simultaneously with distinct modes → no cross-channel interaction; any_evt tracks the OR of sticky.
